// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential shift-add-3 (double-dabble) converter from unsigned binary to
//   packed BCD. One input bit is consumed per clock, and a start/busy/done
//   handshake frames each conversion.
//
// Parameters
//   WIDTH      binary input width in bits (>=1)
//   DIGITS     number of BCD output digits (>=1); bcd is 4*DIGITS bits wide
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   bin        in   unsigned binary value, sampled only on the accepting edge
//   start      in   conversion request, honoured only in IDLE
//   busy       out  high while the converter is shifting
//   done       out  one-cycle pulse; bcd/overflow have just been updated
//   bcd        out  packed BCD with digit 0 in [3:0], held between conversions
//   overflow   out  captured value >= 10**DIGITS, held with bcd
//   dbg_state  out  current FSM state (0 = IDLE, 1 = SHIFT, 2 = DONE)
//
// Handshake
//   A request (start, or the auto-start condition) is accepted only on an
//   edge where the FSM is IDLE. Requests made while busy or done is high are
//   dropped, not queued. done is high for exactly one cycle per completed
//   conversion. busy and done are never high together.
//
// Optional feature (macro BCD_AUTO_START_EN)
//   When defined, a change of bin relative to the last converted value also
//   requests a conversion. The display can then track its input without a
//   start strobe.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_scr;
  logic [CW-1:0]    r_cnt;
  logic             r_sticky;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_scr_shift;
  logic             w_req;
  logic             w_accept;
  logic             w_last;

`ifdef BCD_AUTO_START_EN
  logic [WIDTH-1:0] r_last_bin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_bin <= '0;
    end else if (w_accept) begin
      r_last_bin <= bin;
    end
  end

  assign w_req = start | (bin != r_last_bin);
`else
  assign w_req = start;
`endif

  assign w_accept  = (r_state == S_IDLE) && w_req;
  assign w_last    = (r_cnt == LAST_CNT);
  assign dbg_state = r_state;

  // Add-3 correction: a digit >= 5 would reach >= 10 after doubling, so
  // adding 3 first makes the shift carry it into the next digit.
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
      end
    end
    w_scr_shift = {w_adj[BW-2:0], r_bin[WIDTH-1]};
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register. busy/done are registered decodes of the next state, so
  // they stay glitch-free and line up exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next == S_SHIFT);
      done    <= (w_next == S_DONE);
    end
  end

  // Datapath. A 1 shifted out of the top digit is worth 10**DIGITS. Dropping
  // it leaves value mod 10**DIGITS, and the sticky flag records the loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin    <= '0;
      r_scr    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (w_accept) begin
      r_bin    <= bin;
      r_scr    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_bin    <= r_bin << 1;
      r_scr    <= w_scr_shift;
      r_cnt    <= r_cnt + CW'(1);
      r_sticky <= r_sticky | w_adj[BW-1];
      if (w_last) begin
        bcd      <= w_scr_shift;
        overflow <= r_sticky | w_adj[BW-1];
      end
    end
  end

endmodule
